// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipe scroller: FSM state encoding,
// default playfield geometry, LFSR seed/taps, the speed cap, and the LFSR
// next-state helper.
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        MOVE = 2'd2,
        EVAL = 2'd3
    } state_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int PIPE_W_DEF   = 16;
    localparam int GAP_H_DEF    = 40;
    localparam int SPEED_DEF    = 1;
    localparam int BIRD_X_DEF   = 40;
    localparam int Y_MIN_DEF    = 8;

    // Gap top shown before the first respawn.
    localparam logic [6:0] Y_RESET = 7'd40;

    // Fibonacci taps 8,6,5,4 map to bit indices 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam int MAX_STEP = 4;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), reseeded to 8'hA5 on reset.
// Advances on every clock regardless of the game state.
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   q      out  current LFSR value
// -----------------------------------------------------------------------------
module lfsr8
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    // NOTE: reset is sampled only on the clock edge (synchronous), and all
    // state is updated with non-blocking assignments so every register in the
    // design sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/pipe_scroller.sv
// -----------------------------------------------------------------------------
// pipe_scroller
// Owns one pipe obstacle: scrolls it left once per frame, respawns it at the
// right edge with a pseudo-random gap top, scores each time the pipe's right
// edge passes the bird column, and strobes the collision checker one cycle
// after each position update.
//
// Optional feature macro: PIPE_SPEEDUP_EN
//   defined   : step = min(SPEED + score[7:3], 4)
//   undefined : step = SPEED
//
// Ports
//   clk                 in   system clock
//   reset               in   synchronous, active-high reset
//   enable              in   game running; low freezes the pipe (-> IDLE)
//   frame_tick          in   one-cycle pulse per video frame
//   x_pipe[7:0]         out  pipe left edge
//   y_pipe[6:0]         out  gap top
//   gap_height[7:0]     out  constant GAP_H
//   pipe_width[4:0]     out  constant PIPE_W
//   evaluate_collision  out  one-cycle strobe to the checker
//   score[7:0]          out  points, saturating at 255
//   score_pulse         out  one-cycle pulse on each point
// -----------------------------------------------------------------------------
module pipe_scroller
    import pipe_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int PIPE_W   = PIPE_W_DEF,
    parameter int GAP_H    = GAP_H_DEF,
    parameter int SPEED    = SPEED_DEF,
    parameter int BIRD_X   = BIRD_X_DEF,
    parameter int Y_MIN    = Y_MIN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    output logic [7:0] x_pipe,
    output logic [6:0] y_pipe,
    output logic [7:0] gap_height,
    output logic [4:0] pipe_width,
    output logic       evaluate_collision,
    output logic [7:0] score,
    output logic       score_pulse
);

    localparam logic [7:0] RESPAWN_X = 8'(SCREEN_W - 1);
    localparam logic [8:0] BIRD_X9   = 9'(BIRD_X);
    localparam logic [8:0] PIPE_W9   = 9'(PIPE_W);

    state_t     state;
    state_t     state_next;
    logic [7:0] lfsr_q;
    logic [7:0] step;
    logic [7:0] x_moved;
    logic [8:0] right_now;
    logic [8:0] right_moved;
    logic       crossed;

    logic [7:0] x_next;
    logic [6:0] y_next;
    logic [7:0] score_next;
    logic       eval_next;
    logic       pulse_next;

    // Only the low six LFSR bits pick the gap; the top two are deliberately
    // left unused.
    logic       lfsr_unused;
    assign lfsr_unused = ^lfsr_q[7:6];

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

`ifdef PIPE_SPEEDUP_EN
    logic [7:0] step_raw;
    // One extra pixel per eight points, capped at MAX_STEP.
    assign step_raw = 8'(SPEED) + {3'b000, score[7:3]};
    assign step     = (step_raw > 8'(MAX_STEP)) ? 8'(MAX_STEP) : step_raw;
`else
    assign step = 8'(SPEED);
`endif

    // Scoring compares the pipe's right edge before and after the move in
    // 9 bits so x + PIPE_W cannot wrap. x_moved is only used when x > step.
    assign x_moved     = x_pipe - step;
    assign right_now   = {1'b0, x_pipe}  + PIPE_W9;
    assign right_moved = {1'b0, x_moved} + PIPE_W9;
    assign crossed     = (right_now >= BIRD_X9) && (right_moved < BIRD_X9);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        x_next     = x_pipe;
        y_next     = y_pipe;
        score_next = score;
        eval_next  = 1'b0;
        pulse_next = 1'b0;

        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: state_next = WAIT;
                WAIT: begin
                    if (frame_tick) begin
                        state_next = MOVE;
                    end
                end
                MOVE: begin
                    state_next = EVAL;
                    // Registered, so the strobe is seen during EVAL, after the
                    // new position is already on x_pipe/y_pipe.
                    eval_next  = 1'b1;
                    if (x_pipe <= step) begin
                        x_next = RESPAWN_X;
                        y_next = 7'(Y_MIN) + {1'b0, lfsr_q[5:0]};
                    end else begin
                        x_next = x_moved;
                        if (crossed) begin
                            pulse_next = 1'b1;
                            if (score != 8'hFF) begin
                                score_next = score + 8'd1;
                            end
                        end
                    end
                end
                EVAL:    state_next = WAIT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            x_pipe             <= RESPAWN_X;
            y_pipe             <= Y_RESET;
            score              <= 8'd0;
            evaluate_collision <= 1'b0;
            score_pulse        <= 1'b0;
        end else begin
            state              <= state_next;
            x_pipe             <= x_next;
            y_pipe             <= y_next;
            score              <= score_next;
            evaluate_collision <= eval_next;
            score_pulse        <= pulse_next;
        end
    end

    assign gap_height = 8'(GAP_H);
    assign pipe_width = 5'(PIPE_W);

endmodule

// File: tb/tb_pipe_scroller.sv
// -----------------------------------------------------------------------------
// tb_pipe_scroller
// Self-checking bench for pipe_scroller. A default-parameter instance is
// played frame by frame against a behavioural model of the pipe (position,
// gap, score); a second instance on a narrow, fast playfield is run through
// enough passes to saturate the score.
// -----------------------------------------------------------------------------
module tb_pipe_scroller;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       frame_tick;
    logic [7:0] x_pipe;
    logic [6:0] y_pipe;
    logic [7:0] gap_height;
    logic [4:0] pipe_width;
    logic       evaluate_collision;
    logic [7:0] score;
    logic       score_pulse;

    logic       enable_s;
    logic       frame_tick_s;
    logic [7:0] x_pipe_s;
    logic [6:0] y_pipe_s;
    logic [7:0] gap_height_s;
    logic [4:0] pipe_width_s;
    logic       evaluate_collision_s;
    logic [7:0] score_s;
    logic       score_pulse_s;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model of the default instance.
    int m_x;
    int m_y;
    int m_score;
    // Clock edges since the last reset edge; selects the LFSR value.
    int edges = 0;

    // Model of the narrow instance: SCREEN_W 32, SPEED 4.
    int s_x;
    int s_score;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    pipe_scroller dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .frame_tick         (frame_tick),
        .x_pipe             (x_pipe),
        .y_pipe             (y_pipe),
        .gap_height         (gap_height),
        .pipe_width         (pipe_width),
        .evaluate_collision (evaluate_collision),
        .score              (score),
        .score_pulse        (score_pulse)
    );

    pipe_scroller #(.SCREEN_W(32), .SPEED(4)) dut_sat (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable_s),
        .frame_tick         (frame_tick_s),
        .x_pipe             (x_pipe_s),
        .y_pipe             (y_pipe_s),
        .gap_height         (gap_height_s),
        .pipe_width         (pipe_width_s),
        .evaluate_collision (evaluate_collision_s),
        .score              (score_s),
        .score_pulse        (score_pulse_s)
    );

    // LFSR value n clocks after reseeding: shift left, feedback = x8^x6^x5^x4.
    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < n; i++) begin
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end
        return v;
    endfunction

    function automatic int model_step(input int sc);
`ifdef PIPE_SPEEDUP_EN
        int s;
        s = 1 + sc / 8;
        return (s > 4) ? 4 : s;
`else
        return 1;
`endif
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame on the default instance. Entered on a negedge with the DUT in
    // WAIT; returns on the negedge three cycles later, DUT back in WAIT.
    task automatic frame1();
        int         st;
        int         exp_pulse;
        logic [7:0] l;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        vectors++;
        if (evaluate_collision !== 1'b0) begin
            miscompares++;
            $display("FAIL eval_in_move: got %b expected 0", evaluate_collision);
        end
        l         = lfsr_at(edges);
        st        = model_step(m_score);
        exp_pulse = 0;
        if (m_x <= st) begin
            m_x = 159;
            m_y = 8 + int'(l[5:0]);
        end else begin
            if ((m_x + 16 >= 40) && (m_x - st + 16 < 40)) begin
                exp_pulse = 1;
                if (m_score < 255) m_score++;
            end
            m_x -= st;
        end
        @(negedge clk);
        vectors += 5;
        if (evaluate_collision !== 1'b1) begin
            miscompares++;
            $display("FAIL eval_strobe: got %b expected 1", evaluate_collision);
        end
        if (x_pipe !== 8'(m_x)) begin
            miscompares++;
            $display("FAIL x_pipe: got %0d expected %0d", x_pipe, m_x);
        end
        if (y_pipe !== 7'(m_y)) begin
            miscompares++;
            $display("FAIL y_pipe: got %0d expected %0d", y_pipe, m_y);
        end
        if (score !== 8'(m_score)) begin
            miscompares++;
            $display("FAIL score: got %0d expected %0d", score, m_score);
        end
        if (score_pulse !== 1'(exp_pulse)) begin
            miscompares++;
            $display("FAIL score_pulse: got %b expected %0d", score_pulse, exp_pulse);
        end
        @(negedge clk);
        vectors += 2;
        if (evaluate_collision !== 1'b0) begin
            miscompares++;
            $display("FAIL eval_width: got %b expected 0", evaluate_collision);
        end
        if (score_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_width: got %b expected 0", score_pulse);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        enable       = 1'b0;
        frame_tick   = 1'b0;
        enable_s     = 1'b0;
        frame_tick_s = 1'b0;
        wait_cycles(3);
        vectors += 10;
        if (x_pipe !== 8'd159) begin
            miscompares++; $display("FAIL reset_x: got %0d expected 159", x_pipe);
        end
        if (y_pipe !== 7'd40) begin
            miscompares++; $display("FAIL reset_y: got %0d expected 40", y_pipe);
        end
        if (score !== 8'd0) begin
            miscompares++; $display("FAIL reset_score: got %0d expected 0", score);
        end
        if (evaluate_collision !== 1'b0) begin
            miscompares++; $display("FAIL reset_eval: got %b expected 0", evaluate_collision);
        end
        if (score_pulse !== 1'b0) begin
            miscompares++; $display("FAIL reset_pulse: got %b expected 0", score_pulse);
        end
        if (gap_height !== 8'd40 || gap_height_s !== 8'd40) begin
            miscompares++; $display("FAIL gap_height: got %0d/%0d expected 40", gap_height, gap_height_s);
        end
        if (pipe_width !== 5'd16 || pipe_width_s !== 5'd16) begin
            miscompares++; $display("FAIL pipe_width: got %0d/%0d expected 16", pipe_width, pipe_width_s);
        end
        if (x_pipe_s !== 8'd31) begin
            miscompares++; $display("FAIL reset_x_sat: got %0d expected 31", x_pipe_s);
        end
        if (y_pipe_s !== 7'd40) begin
            miscompares++; $display("FAIL reset_y_sat: got %0d expected 40", y_pipe_s);
        end
        if (score_s !== 8'd0) begin
            miscompares++; $display("FAIL reset_score_sat: got %0d expected 0", score_s);
        end
        reset   = 1'b0;
        m_x     = 159;
        m_y     = 40;
        m_score = 0;
    endtask

    task automatic test_first_frame();
        enable = 1'b1;
        @(negedge clk);          // IDLE -> WAIT
        frame1();
        vectors++;
        if (x_pipe !== 8'd158) begin
            miscompares++; $display("FAIL first_move: got %0d expected 158", x_pipe);
        end
    endtask

    task automatic test_scroll_respawn();
        while (m_x > model_step(m_score)) begin
            frame1();
            wait_cycles($urandom_range(0, 2));
        end
        frame1();
        vectors += 3;
        if (x_pipe !== 8'd159) begin
            miscompares++; $display("FAIL respawn_x: got %0d expected 159", x_pipe);
        end
        if (y_pipe < 7'd8 || y_pipe > 7'd71) begin
            miscompares++; $display("FAIL respawn_y_range: got %0d expected 8..71", y_pipe);
        end
        if (score !== 8'd1) begin
            miscompares++; $display("FAIL one_pass_score: got %0d expected 1", score);
        end
    endtask

    task automatic test_enable_low();
        // Tick arrives while enable is low: nothing moves, nothing strobes.
        enable     = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors += 2;
            if (x_pipe !== 8'(m_x)) begin
                miscompares++; $display("FAIL frozen_x: got %0d expected %0d", x_pipe, m_x);
            end
            if (evaluate_collision !== 1'b0) begin
                miscompares++; $display("FAIL frozen_eval: got %b expected 0", evaluate_collision);
            end
            @(negedge clk);
        end
        enable = 1'b1;
        @(negedge clk);          // IDLE -> WAIT
        // Enable dropped while in MOVE: the move is abandoned.
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        enable     = 1'b0;
        @(negedge clk);
        vectors += 3;
        if (x_pipe !== 8'(m_x)) begin
            miscompares++; $display("FAIL abort_x: got %0d expected %0d", x_pipe, m_x);
        end
        if (evaluate_collision !== 1'b0) begin
            miscompares++; $display("FAIL abort_eval: got %b expected 0", evaluate_collision);
        end
        if (score_pulse !== 1'b0) begin
            miscompares++; $display("FAIL abort_pulse: got %b expected 0", score_pulse);
        end
        enable = 1'b1;
        @(negedge clk);          // IDLE -> WAIT
        frame1();
    endtask

    task automatic test_dropped_tick();
        int st;
        // Tick held through MOVE: the second sample must be ignored.
        frame_tick = 1'b1;
        @(negedge clk);
        st = model_step(m_score);
        if (m_x <= st) begin
            m_x = 159;
            m_y = 8 + int'(lfsr_at(edges) & 8'h3F);
        end else begin
            if ((m_x + 16 >= 40) && (m_x - st + 16 < 40) && m_score < 255) m_score++;
            m_x -= st;
        end
        @(negedge clk);
        frame_tick = 1'b0;
        wait_cycles(3);
        vectors += 3;
        if (x_pipe !== 8'(m_x)) begin
            miscompares++; $display("FAIL dropped_tick_x: got %0d expected %0d", x_pipe, m_x);
        end
        if (score !== 8'(m_score)) begin
            miscompares++; $display("FAIL dropped_tick_score: got %0d expected %0d", score, m_score);
        end
        if (evaluate_collision !== 1'b0) begin
            miscompares++; $display("FAIL dropped_tick_eval: got %b expected 0", evaluate_collision);
        end
    endtask

    task automatic test_reset_in_move();
        frame_tick = 1'b1;
        @(negedge clk);          // MOVE
        frame_tick = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        vectors += 5;
        if (x_pipe !== 8'd159) begin
            miscompares++; $display("FAIL mid_reset_x: got %0d expected 159", x_pipe);
        end
        if (y_pipe !== 7'd40) begin
            miscompares++; $display("FAIL mid_reset_y: got %0d expected 40", y_pipe);
        end
        if (score !== 8'd0) begin
            miscompares++; $display("FAIL mid_reset_score: got %0d expected 0", score);
        end
        if (evaluate_collision !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset_eval: got %b expected 0", evaluate_collision);
        end
        if (score_pulse !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset_pulse: got %b expected 0", score_pulse);
        end
        m_x     = 159;
        m_y     = 40;
        m_score = 0;
        // Back in IDLE: a tick seen there is not acted on.
        reset      = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        wait_cycles(2);
        vectors += 2;
        if (x_pipe !== 8'd159) begin
            miscompares++; $display("FAIL idle_tick_x: got %0d expected 159", x_pipe);
        end
        if (evaluate_collision !== 1'b0) begin
            miscompares++; $display("FAIL idle_tick_eval: got %b expected 0", evaluate_collision);
        end
    endtask

    task automatic test_random_play();
        for (int f = 0; f < 260; f++) begin
            if ($urandom_range(0, 15) == 0) begin
                enable = 1'b0;
                wait_cycles($urandom_range(1, 3));
                enable = 1'b1;
                @(negedge clk);  // IDLE -> WAIT
            end
            frame1();
            wait_cycles($urandom_range(0, 3));
        end
    endtask

    task automatic test_saturation();
        int exp_pulse;
        enable   = 1'b0;
        enable_s = 1'b1;
        s_x      = 31;
        s_score  = 0;
        @(negedge clk);          // IDLE -> WAIT
        for (int f = 0; f < 262 * 8; f++) begin
            frame_tick_s = 1'b1;
            @(negedge clk);
            frame_tick_s = 1'b0;
            exp_pulse    = 0;
            if (s_x <= 4) begin
                s_x = 31;
            end else begin
                if ((s_x + 16 >= 40) && (s_x - 4 + 16 < 40)) begin
                    exp_pulse = 1;
                    if (s_score < 255) s_score++;
                end
                s_x -= 4;
            end
            @(negedge clk);
            vectors += 4;
            if (x_pipe_s !== 8'(s_x)) begin
                miscompares++; $display("FAIL sat_x: got %0d expected %0d", x_pipe_s, s_x);
            end
            if (score_s !== 8'(s_score)) begin
                miscompares++; $display("FAIL sat_score: got %0d expected %0d", score_s, s_score);
            end
            if (score_pulse_s !== 1'(exp_pulse)) begin
                miscompares++; $display("FAIL sat_pulse: got %b expected %0d", score_pulse_s, exp_pulse);
            end
            if (evaluate_collision_s !== 1'b1) begin
                miscompares++; $display("FAIL sat_eval: got %b expected 1", evaluate_collision_s);
            end
            @(negedge clk);
        end
        vectors++;
        if (score_s !== 8'd255) begin
            miscompares++; $display("FAIL saturated_score: got %0d expected 255", score_s);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_scroll_respawn();
        test_enable_low();
        test_dropped_tick();
        test_reset_in_move();
        enable = 1'b1;
        @(negedge clk);          // IDLE -> WAIT
        test_random_play();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, vectors %0d expected run to complete", vectors);
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
